// File: rtl/elevator_car_controller.sv
// Elevator car controller: latches call buttons, steps the car one floor at a time
// toward pending requests, and times the door at each served floor.
module elevator_car_controller #(
  parameter int NUM_FLOORS    = 6,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_FLOORS-1:0] callButtons,
  input  logic                  Up,
  input  logic                  Down,
  input  logic                  holdDoor,
  output logic [NUM_FLOORS-1:0] currentFloor,
  output logic [NUM_FLOORS-1:0] inputfloors,
  output logic                  doorOpen,
  output logic                  moving
);

  localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0]         TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0]         DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_F       = NUM_FLOORS'(1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

  // All controller state in one struct so checkers can bind to ctl_q directly.
  typedef struct packed {
    state_t        state;
    logic          dir_up;
    logic [CW-1:0] cnt;
  } ctl_t;

  ctl_t                  ctl_q, ctl_d;
  logic [NUM_FLOORS-1:0] cur_d;
  logic [NUM_FLOORS-1:0] req_d;
  logic [NUM_FLOORS-1:0] clear_mask;

  // Floors strictly above / below a one-hot position.
  function automatic logic [NUM_FLOORS-1:0] above_of(input logic [NUM_FLOORS-1:0] f);
    return ~((f << 1) - ONE_F);
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_of(input logic [NUM_FLOORS-1:0] f);
    return f - ONE_F;
  endfunction

  always_comb begin
    ctl_d = ctl_q;
    cur_d = currentFloor;
    case (ctl_q.state)
      IDLE: begin
        if (|(inputfloors & currentFloor)) begin
          ctl_d.state = DOOR_OPEN;
          ctl_d.cnt   = DOOR_LOAD;
        end else if (Up && |(inputfloors & above_of(currentFloor))) begin
          ctl_d.state  = MOVING;
          ctl_d.dir_up = 1'b1;
          ctl_d.cnt    = '0;
        end else if (!Up && Down && |(inputfloors & below_of(currentFloor))) begin
          ctl_d.state  = MOVING;
          ctl_d.dir_up = 1'b0;
          ctl_d.cnt    = '0;
        end
      end
      MOVING: begin
        if (ctl_q.cnt == TRAVEL_LAST) begin
          if (ctl_q.dir_up && !currentFloor[NUM_FLOORS-1]) cur_d = currentFloor << 1;
          else if (!ctl_q.dir_up && !currentFloor[0])      cur_d = currentFloor >> 1;
          ctl_d.cnt = '0;
          // A press landing on the arrival edge still stops the car here.
          if (|((inputfloors | callButtons) & cur_d)) begin
            ctl_d.state = DOOR_OPEN;
            ctl_d.cnt   = DOOR_LOAD;
          end else if (ctl_q.dir_up ? |(inputfloors & above_of(cur_d))
                                    : |(inputfloors & below_of(cur_d))) begin
            ctl_d.state = MOVING;
          end else begin
            ctl_d.state = IDLE;
          end
        end else begin
          ctl_d.cnt = ctl_q.cnt + 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (holdDoor || |(callButtons & currentFloor)) ctl_d.cnt = DOOR_LOAD;
        else if (ctl_q.cnt == '0)                      ctl_d.state = IDLE;
        else                                           ctl_d.cnt = ctl_q.cnt - 1'b1;
      end
      default: ctl_d.state = IDLE;
    endcase
    // The served floor is cleared on entry to and while in DOOR_OPEN; clear beats set there.
    clear_mask = (ctl_d.state == DOOR_OPEN) ? cur_d : '0;
    req_d      = (inputfloors | callButtons) & ~clear_mask;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ctl_q        <= '{state: IDLE, dir_up: 1'b1, cnt: '0};
      currentFloor <= ONE_F;
      inputfloors  <= '0;
      doorOpen     <= 1'b0;
      moving       <= 1'b0;
    end else begin
      ctl_q        <= ctl_d;
      currentFloor <= cur_d;
      inputfloors  <= req_d;
      doorOpen     <= (ctl_d.state == DOOR_OPEN);
      moving       <= (ctl_d.state == MOVING);
    end
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: directed trips plus random calls and
// direction hints, checked every cycle against a floor-index reference model.
module tb_elevator_car_controller;

  localparam int N  = 6;
  localparam int TC = 4;
  localparam int DC = 3;
  localparam int W  = 2 * N + 2;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [N-1:0] callButtons;
  logic         Up;
  logic         Down;
  logic         holdDoor;
  logic [N-1:0] currentFloor;
  logic [N-1:0] inputfloors;
  logic         doorOpen;
  logic         moving;

  elevator_car_controller #(
    .NUM_FLOORS    (N),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .callButtons  (callButtons),
    .Up           (Up),
    .Down         (Down),
    .holdDoor     (holdDoor),
    .currentFloor (currentFloor),
    .inputfloors  (inputfloors),
    .doorOpen     (doorOpen),
    .moving       (moving)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: {floor, requests, door, moving} per cycle
  logic [W-1:0] exp_q[$];

  // reference model: floor as an index, requests as a bit list
  int m_floor;
  bit m_pend[N];
  int m_mode;        // 0 = parked, 1 = travelling, 2 = door open
  bit m_going_up;
  int m_travel_left;
  int m_door_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pend_between(input int lo, input int hi);
    for (int i = 0; i < N; i++)
      if (i >= lo && i <= hi && m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_mode        = 0;
    m_going_up    = 1'b1;
    m_travel_left = 0;
    m_door_left   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] cb, input logic up, input logic dn,
                            input logic hold);
    int           nf;
    int           nmode;
    logic [N-1:0] fl;
    logic [N-1:0] pv;
    nf    = m_floor;
    nmode = m_mode;
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          nmode = 2; m_door_left = DC;
        end else if (up && pend_between(m_floor + 1, N - 1)) begin
          nmode = 1; m_going_up = 1'b1; m_travel_left = TC;
        end else if (!up && dn && pend_between(0, m_floor - 1)) begin
          nmode = 1; m_going_up = 1'b0; m_travel_left = TC;
        end
      end
      1: begin
        m_travel_left--;
        if (m_travel_left == 0) begin
          nf = m_going_up ? m_floor + 1 : m_floor - 1;
          m_travel_left = TC;
          if (m_pend[nf] || cb[nf]) begin
            nmode = 2; m_door_left = DC;
          end else if (m_going_up ? pend_between(nf + 1, N - 1) : pend_between(0, nf - 1)) begin
            nmode = 1;
          end else begin
            nmode = 0;
          end
        end
      end
      default: begin
        if (hold || cb[m_floor]) m_door_left = DC;
        else if (m_door_left == 1) nmode = 0;
        else m_door_left--;
      end
    endcase
    for (int i = 0; i < N; i++) m_pend[i] = m_pend[i] | cb[i];
    if (nmode == 2) m_pend[nf] = 1'b0;
    m_floor = nf;
    m_mode  = nmode;
    fl = '0;
    fl[m_floor] = 1'b1;
    for (int i = 0; i < N; i++) pv[i] = m_pend[i];
    exp_q.push_back({fl, pv, (m_mode == 2), (m_mode == 1)});
  endtask

  // driver: one clock cycle of stimulus, then compare against the scoreboard
  task automatic run_cycle(input logic [N-1:0] cb, input logic up, input logic dn,
                           input logic hold);
    logic [W-1:0] e;
    @(negedge Clock);
    callButtons = cb;
    Up          = up;
    Down        = dn;
    holdDoor    = hold;
    model_step(cb, up, dn, hold);
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    check("currentFloor", 32'(currentFloor), 32'(e[W-1 -: N]));
    check("inputfloors",  32'(inputfloors),  32'(e[N+1 -: N]));
    check("doorOpen",     32'(doorOpen),     32'(e[1]));
    check("moving",       32'(moving),       32'(e[0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_floor"},  32'(currentFloor), 32'h1);
    check({tag, "_req"},    32'(inputfloors),  32'h0);
    check({tag, "_door"},   32'(doorOpen),     32'h0);
    check({tag, "_moving"}, 32'(moving),       32'h0);
  endtask

  int door_hi;
  logic r_up, r_dn, r_hold;
  logic [N-1:0] r_cb;

  initial begin
    Reset       = 1'b1;
    callButtons = '0;
    Up          = 1'b0;
    Down        = 1'b0;
    holdDoor    = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("init_reset");
    @(negedge Clock);
    Reset = 1'b0;

    // same-floor call at ground
    run_cycle(6'b000001, 1'b1, 1'b0, 1'b0);
    repeat (6) run_cycle('0, 1'b1, 1'b0, 1'b0);

    // simple up trip to floor 3
    run_cycle(6'b001000, 1'b1, 1'b0, 1'b0);
    repeat (25) run_cycle('0, 1'b1, 1'b0, 1'b0);

    // back down to ground
    run_cycle(6'b000001, 1'b0, 1'b1, 1'b0);
    repeat (25) run_cycle('0, 1'b0, 1'b1, 1'b0);

    // intermediate stop at 2, then on to 4
    run_cycle(6'b010100, 1'b1, 1'b0, 1'b0);
    repeat (35) run_cycle('0, 1'b1, 1'b0, 1'b0);

    // down to floor 3
    run_cycle(6'b001000, 1'b0, 1'b1, 1'b0);
    repeat (15) run_cycle('0, 1'b0, 1'b1, 1'b0);

    // stale Up pointing away from the only request: car must wait
    run_cycle(6'b000010, 1'b1, 1'b0, 1'b0);
    repeat (10) run_cycle('0, 1'b1, 1'b0, 1'b0);
    check("dirwait_parked", 32'(moving), 32'h0);
    repeat (20) run_cycle('0, 1'b0, 1'b1, 1'b0);
    check("dirwait_arrive", 32'(currentFloor), 32'h2);

    // door extend: hold for 5 cycles starting at the first open cycle
    run_cycle(6'b000010, 1'b0, 1'b0, 1'b0);
    door_hi = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle('0, 1'b0, 1'b0, (i >= 1 && i <= 5));
      if (doorOpen) door_hi++;
    end
    check("door_extend_len", 32'(door_hi), 32'd8);

    // async reset while travelling
    run_cycle(6'b100000, 1'b1, 1'b0, 1'b0);
    run_cycle('0, 1'b1, 1'b0, 1'b0);
    run_cycle('0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_moving", 32'(moving), 32'h1);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge Clock);
    #1;
    check_reset_outputs("held_reset");
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();

    // random calls, direction hints and door holds
    r_up = 1'b1;
    r_dn = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 8 == 0) begin
        r_up = 1'($urandom_range(0, 1));
        r_dn = 1'($urandom_range(0, 1));
      end
      r_cb = '0;
      if ($urandom_range(0, 7) == 0) r_cb[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 40) == 0) r_cb = N'($urandom_range(0, (1 << N) - 1));
      r_hold = ($urandom_range(0, 15) == 0);
      run_cycle(r_cb, r_up, r_dn, r_hold);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
- Owns the car's physical state: latches hall/car call buttons into a pending-request register, moves the car one floor at a time, and runs the door timer.
- Sits directly upstream of elevatorDirection:
  - It drives that block's currentFloor and inputfloors inputs.
  - It consumes that block's Up/Down outputs to choose which way to travel.

Parameters:
- NUM_FLOORS, 6, number of floors; one-hot floor and request vectors are NUM_FLOORS wide.
- TRAVEL_CYCLES, 4, clock cycles spent moving between adjacent floors (≥1).
- DOOR_CYCLES, 3, clock cycles doorOpen stays high per stop (≥1).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- callButtons  input  NUM_FLOORS  request pulses; bit i = floor i requested; multiple bits allowed.
- Up  input  1  from elevatorDirection: preferred direction is up.
- Down  input  1  from elevatorDirection: preferred direction is down.
- holdDoor  input  1  while high in DOOR_OPEN, door timer held at its reload value.
- currentFloor  output  NUM_FLOORS  one-hot car position, bit 0 = ground floor.
- inputfloors  output  NUM_FLOORS  registered pending-request bitmap.
- doorOpen  output  1  door open indicator.
- moving  output  1  high while in MOVING.

Behaviour:
- Reset (async, active-high, no clock edge needed): currentFloor=000001, inputfloors=0, doorOpen=0, moving=0, state=IDLE, counters=0, latched direction=up.
- Request capture:
  - Each edge, inputfloors <= (inputfloors | callButtons) & ~clearMask.
  - clearMask = currentFloor in any cycle where the FSM enters or stays in DOOR_OPEN; otherwise 0.
  - A press at the floor being served while the door is open is therefore absorbed and never appears.
- FSM decisions use registered inputfloors only. A press sampled at edge k is visible after edge k and acted on at edge k+1.
- States: IDLE, MOVING, DOOR_OPEN. Outputs are registered. moving=1 iff state==MOVING. doorOpen=1 iff state==DOOR_OPEN.
- IDLE (priority order):
  1. If (inputfloors & currentFloor)≠0: go to DOOR_OPEN and load the door counter.
  2. Else if Up=1 and any request above currentFloor: go to MOVING, latch dir=up, clear the travel counter.
  3. Else if Down=1 and any request below currentFloor: go to MOVING, latch dir=down.
  4. Else stay in IDLE. This covers a stale Up/Down pointing away from all requests; wait for elevatorDirection to flip.
- MOVING:
  - The travel counter increments each cycle.
  - On the cycle it reaches TRAVEL_CYCLES-1, currentFloor shifts one position in the latched dir (left = up), the counter clears, and the next state is chosen for the new floor:
    - DOOR_OPEN if the new floor is requested, including a callButtons bit arriving on this same edge.
    - Else MOVING if requests remain beyond the new floor in the latched dir.
    - Else IDLE.
  - Up/Down changes during MOVING are ignored.
- DOOR_OPEN:
  - The counter loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - holdDoor=1 or a callButtons press at currentFloor reloads the counter.
  - At 0, go to IDLE.
- Boundaries:
  - currentFloor never shifts past bit 0 or bit NUM_FLOORS-1.
  - A MOVING entry toward a nonexistent floor cannot occur, because of the request-above/below qualification.
  - currentFloor is always exactly one-hot.
- Simultaneous set and clear of the same inputfloors bit: clear wins, but only in DOOR_OPEN. In MOVING and IDLE the set wins.
- Up=Down=1 is treated as Up. Up=Down=0 means no move.

Test Plan:
- Reset: assert Reset mid-cycle, no edge → currentFloor=000001, inputfloors=0, doorOpen=0, moving=0 immediately.
- Simple up trip: idle at floor 0, Up=1, callButtons=001000 for 1 cycle → inputfloors=001000 next cycle, moving=1 the cycle after. currentFloor steps 000010→000100→001000, 4 cycles apart. doorOpen=1 for 3 cycles with inputfloors=000000. Then IDLE.
- Same-floor call: idle at floor 0, callButtons=000001 → doorOpen for 3 cycles, moving never asserts, currentFloor unchanged.
- Intermediate stop: at floor 0, Up=1, callButtons=010100 → stop at 000100 (door 3 cycles, bit 2 cleared), then continue to 010000, inputfloors=000000 at end.
- Direction wait: at floor 3, Up=1, Down=0, callButtons=000010 → stays IDLE. After Down=1, Up=0 → moves down, reaching 000010 after 2×4 cycles.
- Door extend and async reset: holdDoor=1 for 5 cycles during DOOR_OPEN → doorOpen high 5+3 cycles. Then assert Reset while moving=1 → all outputs return to reset values asynchronously and stay until Reset deasserts.
